pcie_lite_requester: RTL and testbench

Requester (initiator) side of the lite TLP interface. It converts single-DW user read/write requests into MRd and MWr TLPs, allocates and tracks read tags, and matches incoming CplD completions to outstanding reads. Per-tag completion timeouts are enforced, and every read returns exactly one response to the user. It sits between the host-side test/user logic and the lite PCIe endpoint.

---
 rtl/pcie_lite_requester.sv | 240 ++++++++++++++++++++++++
 tb/tb_pcie_lite_requester.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_lite_requester.sv
// Requester side of the lite TLP interface: turns single-DW user requests into MRd/MWr TLPs,
// tracks read tags with per-tag completion timers and returns exactly one response per read.
module pcie_lite_requester #(
  parameter int NUM_TAGS    = 8,
  parameter int CPL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_up,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        tlp_valid,
  input  logic        tlp_ready,
  output logic [2:0]  tlp_type,
  output logic [31:0] tlp_address,
  output logic [31:0] tlp_data,
  output logic [7:0]  tlp_tag,
  output logic [9:0]  tlp_length,
  input  logic        cpl_valid,
  output logic        cpl_ready,
  input  logic [2:0]  cpl_status,
  input  logic [31:0] cpl_data,
  input  logic [7:0]  cpl_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_tag,
  output logic [31:0] rsp_data,
  output logic [2:0]  rsp_status,
  output logic        err_unexpected,
  output logic        err_timeout,
  output logic [5:0]  outstanding
);

  localparam logic [2:0]  TYPE_MRD       = 3'b000;
  localparam logic [2:0]  TYPE_MWR       = 3'b001;
  localparam logic [2:0]  STATUS_TIMEOUT = 3'b011;
  localparam logic [15:0] TIMER_LOAD     = 16'(CPL_TIMEOUT);

  logic                tlpValid_q, tlpValid_d;
  logic [2:0]          tlpType_q, tlpType_d;
  logic [31:0]         tlpAddr_q, tlpAddr_d;
  logic [31:0]         tlpData_q, tlpData_d;
  logic [7:0]          tlpTag_q, tlpTag_d;
  logic [9:0]          tlpLength_q, tlpLength_d;

  logic                rspValid_q, rspValid_d;
  logic [7:0]          rspTag_q, rspTag_d;
  logic [31:0]         rspData_q, rspData_d;
  logic [2:0]          rspStatus_q, rspStatus_d;

  logic                errUnexpected_q, errUnexpected_d;
  logic                errTimeout_q, errTimeout_d;
  logic [5:0]          outstanding_q, outstanding_d;

  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [15:0]         timer_q [NUM_TAGS];
  logic [15:0]         timer_d [NUM_TAGS];

  logic                allocFound;
  logic [4:0]          allocIdx;
  logic [NUM_TAGS-1:0] allocMask;
  logic                reqReady, reqAccept, readAccept;
  logic                cplAccept, cplHit, cplMatch;
  logic [NUM_TAGS-1:0] cplMask;
  logic                expFound, serviceTimeout;
  logic [4:0]          expIdx;
  logic [NUM_TAGS-1:0] expMask;
  logic [NUM_TAGS-1:0] freeMask;

  // Allocation, completion matching and expiry selection all look at the tag state as it
  // stood at the start of the cycle, so a tag freed this cycle is never re-issued this cycle.
  always_comb begin
    allocFound = 1'b0;
    allocIdx   = '0;
    allocMask  = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (!busy_q[i] && !allocFound) begin
        allocFound   = 1'b1;
        allocIdx     = 5'(i);
        allocMask[i] = 1'b1;
      end
    end

    reqReady   = link_up && !tlpValid_q && (req_write || allocFound);
    reqAccept  = req_valid && reqReady;
    readAccept = reqAccept && !req_write;

    cplAccept = cpl_valid && !rspValid_q;
    cplHit    = 1'b0;
    cplMask   = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (cpl_tag == 8'(i) && busy_q[i]) begin
        cplHit     = 1'b1;
        cplMask[i] = 1'b1;
      end
    end
    cplMatch = cplAccept && cplHit;

    expFound = 1'b0;
    expIdx   = '0;
    expMask  = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (busy_q[i] && timer_q[i] == 16'd0 && !expFound) begin
        expFound   = 1'b1;
        expIdx     = 5'(i);
        expMask[i] = 1'b1;
      end
    end
    serviceTimeout = !rspValid_q && !cplAccept && expFound;

    freeMask = '0;
    if (cplMatch) begin
      freeMask = cplMask;
    end else if (serviceTimeout) begin
      freeMask = expMask;
    end

    busy_d = (busy_q & ~freeMask) | (readAccept ? allocMask : '0);

    for (int i = 0; i < NUM_TAGS; i++) begin
      timer_d[i] = timer_q[i];
      if (readAccept && allocMask[i]) begin
        timer_d[i] = TIMER_LOAD;
      end else if (freeMask[i]) begin
        timer_d[i] = '0;
      end else if (busy_q[i] && timer_q[i] != 16'd0) begin
        timer_d[i] = timer_q[i] - 16'd1;
      end
    end

    outstanding_d = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      outstanding_d = outstanding_d + 6'(busy_d[i]);
    end
  end

  // TLP output register: loaded on accept, held until the downstream handshake.
  always_comb begin
    tlpValid_d  = tlpValid_q;
    tlpType_d   = tlpType_q;
    tlpAddr_d   = tlpAddr_q;
    tlpData_d   = tlpData_q;
    tlpTag_d    = tlpTag_q;
    tlpLength_d = tlpLength_q;
    if (reqAccept) begin
      tlpValid_d  = 1'b1;
      tlpType_d   = req_write ? TYPE_MWR : TYPE_MRD;
      tlpAddr_d   = req_addr;
      tlpData_d   = req_write ? req_data : 32'd0;
      tlpTag_d    = req_write ? 8'hFF : {3'b000, allocIdx};
      tlpLength_d = 10'd1;
    end else if (tlpValid_q && tlp_ready) begin
      tlpValid_d = 1'b0;
    end
  end

  // Response register: new responses are only produced while it is empty.
  always_comb begin
    rspValid_d  = rspValid_q;
    rspTag_d    = rspTag_q;
    rspData_d   = rspData_q;
    rspStatus_d = rspStatus_q;
    if (cplMatch) begin
      rspValid_d  = 1'b1;
      rspTag_d    = cpl_tag;
      rspData_d   = cpl_data;
      rspStatus_d = cpl_status;
    end else if (serviceTimeout) begin
      rspValid_d  = 1'b1;
      rspTag_d    = {3'b000, expIdx};
      rspData_d   = 32'd0;
      rspStatus_d = STATUS_TIMEOUT;
    end else if (rspValid_q && rsp_ready) begin
      rspValid_d = 1'b0;
    end

    errUnexpected_d = cplAccept && !cplHit;
    errTimeout_d    = serviceTimeout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tlpValid_q      <= 1'b0;
      tlpType_q       <= '0;
      tlpAddr_q       <= '0;
      tlpData_q       <= '0;
      tlpTag_q        <= '0;
      tlpLength_q     <= '0;
      rspValid_q      <= 1'b0;
      rspTag_q        <= '0;
      rspData_q       <= '0;
      rspStatus_q     <= '0;
      errUnexpected_q <= 1'b0;
      errTimeout_q    <= 1'b0;
      outstanding_q   <= '0;
      busy_q          <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      tlpValid_q      <= tlpValid_d;
      tlpType_q       <= tlpType_d;
      tlpAddr_q       <= tlpAddr_d;
      tlpData_q       <= tlpData_d;
      tlpTag_q        <= tlpTag_d;
      tlpLength_q     <= tlpLength_d;
      rspValid_q      <= rspValid_d;
      rspTag_q        <= rspTag_d;
      rspData_q       <= rspData_d;
      rspStatus_q     <= rspStatus_d;
      errUnexpected_q <= errUnexpected_d;
      errTimeout_q    <= errTimeout_d;
      outstanding_q   <= outstanding_d;
      busy_q          <= busy_d;
      for (int i = 0; i < NUM_TAGS; i++) begin
        timer_q[i] <= timer_d[i];
      end
    end
  end

  assign req_ready      = reqReady;
  assign cpl_ready      = !rspValid_q;
  assign tlp_valid      = tlpValid_q;
  assign tlp_type       = tlpType_q;
  assign tlp_address    = tlpAddr_q;
  assign tlp_data       = tlpData_q;
  assign tlp_tag        = tlpTag_q;
  assign tlp_length     = tlpLength_q;
  assign rsp_valid      = rspValid_q;
  assign rsp_tag        = rspTag_q;
  assign rsp_data       = rspData_q;
  assign rsp_status     = rspStatus_q;
  assign err_unexpected = errUnexpected_q;
  assign err_timeout    = errTimeout_q;
  assign outstanding    = outstanding_q;

endmodule

// File: tb/tb_pcie_lite_requester.sv
// Directed bench for pcie_lite_requester: request/TLP path, tag allocation, completions,
// timeouts, backpressure and reset, each step compared against hand-computed values.
`timescale 1ns/1ps
module tb_pcie_lite_requester;
  localparam int NUM_TAGS = 8;
  localparam int TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_up;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_data;
  logic        tlp_valid, tlp_ready;
  logic [2:0]  tlp_type;
  logic [31:0] tlp_address, tlp_data;
  logic [7:0]  tlp_tag;
  logic [9:0]  tlp_length;
  logic        cpl_valid, cpl_ready;
  logic [2:0]  cpl_status;
  logic [31:0] cpl_data;
  logic [7:0]  cpl_tag;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_tag;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_status;
  logic        err_unexpected, err_timeout;
  logic [5:0]  outstanding;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int toPulses = 0;
  int unexpPulses = 0;

  pcie_lite_requester #(.NUM_TAGS(NUM_TAGS), .CPL_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .link_up(link_up),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_type(tlp_type),
    .tlp_address(tlp_address), .tlp_data(tlp_data), .tlp_tag(tlp_tag),
    .tlp_length(tlp_length),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_status(cpl_status),
    .cpl_data(cpl_data), .cpl_tag(cpl_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .err_unexpected(err_unexpected), .err_timeout(err_timeout),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  // Error pulses are tallied at the rising edge, which sees the value held over the previous cycle.
  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
    if (err_timeout)    toPulses    <= toPulses + 1;
    if (err_unexpected) unexpPulses <= unexpPulses + 1;
  end

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Presents one request from a falling edge and returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bit done = 1'b0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_data  = data;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      if (req_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    req_write = 1'b0;
    if (!done) checkOutput("req_accept_bound", 1'b0, 1'b1);
  endtask

  task automatic applyCompletion(input logic [7:0] tag, input logic [2:0] st, input logic [31:0] data);
    bit done = 1'b0;
    cpl_valid  = 1'b1;
    cpl_tag    = tag;
    cpl_status = st;
    cpl_data   = data;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      if (cpl_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    cpl_valid = 1'b0;
    if (!done) checkOutput("cpl_accept_bound", 1'b0, 1'b1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startCycle, latency, toBase, unBase;
    bit found;
    rst_n = 1'b0; link_up = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_data = '0; tlp_ready = 1'b1; cpl_valid = 1'b0;
    cpl_status = '0; cpl_data = '0; cpl_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rst_tlp_valid", tlp_valid, 1'b0);
    checkOutput("rst_tlp_fields", {tlp_type, tlp_address, tlp_data, tlp_tag, tlp_length}, '0);
    checkOutput("rst_rsp", {rsp_valid, rsp_tag, rsp_data, rsp_status}, '0);
    checkOutput("rst_errs", {err_unexpected, err_timeout}, 2'b00);
    checkOutput("rst_outstanding", outstanding, 6'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single read");
    applyStimulus(1'b0, 32'h40, 32'h0);
    checkOutput("rd_tlp_valid", tlp_valid, 1'b1);
    checkOutput("rd_tlp_fields", {tlp_type, tlp_address, tlp_data, tlp_tag, tlp_length},
                {3'b000, 32'h40, 32'h0, 8'h00, 10'd1});
    checkOutput("rd_outstanding_1", outstanding, 6'd1);
    applyCompletion(8'h00, 3'b000, 32'hDEADBEEF);
    checkOutput("rd_rsp_valid", rsp_valid, 1'b1);
    checkOutput("rd_rsp_fields", {rsp_tag, rsp_status, rsp_data}, {8'h00, 3'b000, 32'hDEADBEEF});
    checkOutput("rd_outstanding_0", outstanding, 6'd0);
    checkOutput("rd_tlp_cleared", tlp_valid, 1'b0);
    @(negedge clk);
    checkOutput("rd_rsp_cleared", rsp_valid, 1'b0);

    $display("[TB] write with tlp_ready held low");
    tlp_ready = 1'b0;
    applyStimulus(1'b1, 32'h10, 32'h12345678);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("wr_hold_%0d", k),
                  {tlp_valid, tlp_type, tlp_address, tlp_data, tlp_tag, tlp_length},
                  {1'b1, 3'b001, 32'h10, 32'h12345678, 8'hFF, 10'd1});
      if (k == 3) tlp_ready = 1'b1;
      @(negedge clk);
    end
    checkOutput("wr_tlp_cleared", tlp_valid, 1'b0);
    checkOutput("wr_no_rsp", rsp_valid, 1'b0);
    checkOutput("wr_outstanding", outstanding, 6'd0);

    $display("[TB] fill all tags");
    for (int i = 0; i < NUM_TAGS; i++) begin
      applyStimulus(1'b0, 32'h1000 + 32'(i * 4), 32'h0);
      checkOutput($sformatf("full_tag_%0d", i), tlp_tag, 8'(i));
    end
    checkOutput("full_outstanding", outstanding, 6'd8);
    @(negedge clk);
    req_write = 1'b0;
    #1 checkOutput("full_read_ready", req_ready, 1'b0);
    req_write = 1'b1;
    #1 checkOutput("full_write_ready", req_ready, 1'b1);
    req_write = 1'b0;
    applyCompletion(8'h03, 3'b000, 32'h33333333);
    checkOutput("full_rsp_tag3", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 8'h03, 32'h33333333});
    checkOutput("full_outstanding_7", outstanding, 6'd7);
    applyStimulus(1'b0, 32'h2000, 32'h0);
    checkOutput("full_realloc_tag", tlp_tag, 8'h03);
    checkOutput("full_outstanding_8", outstanding, 6'd8);
    doReset();

    $display("[TB] completion timeout");
    applyStimulus(1'b0, 32'h80, 32'h0);
    startCycle = cycleCount;
    toBase = toPulses;
    found = 1'b0;
    latency = 0;
    for (int n = 0; n < TIMEOUT + 10 && !found; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1'b1;
        latency = cycleCount - startCycle;
      end
    end
    checkOutput("to_rsp_seen", found, 1'b1);
    checkOutput("to_latency", latency, TIMEOUT + 1);
    checkOutput("to_rsp_fields", {rsp_tag, rsp_status, rsp_data}, {8'h00, 3'b011, 32'h0});
    checkOutput("to_err_pulse", err_timeout, 1'b1);
    checkOutput("to_outstanding", outstanding, 6'd0);
    repeat (3) @(negedge clk);
    checkOutput("to_err_count", toPulses - toBase, 1);
    checkOutput("to_rsp_cleared", rsp_valid, 1'b0);

    $display("[TB] unexpected completions");
    unBase = unexpPulses;
    applyCompletion(8'h05, 3'b000, 32'h55);
    checkOutput("unexp_pulse", err_unexpected, 1'b1);
    checkOutput("unexp_no_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    checkOutput("unexp_pulse_end", err_unexpected, 1'b0);
    applyCompletion(8'h09, 3'b000, 32'h99);
    checkOutput("unexp_range_pulse", {err_unexpected, rsp_valid}, 2'b10);
    repeat (2) @(negedge clk);
    checkOutput("unexp_count", unexpPulses - unBase, 2);

    $display("[TB] completion on expiry cycle");
    toBase = toPulses;
    applyStimulus(1'b0, 32'hC0, 32'h0);
    repeat (TIMEOUT) @(negedge clk);
    applyCompletion(8'h00, 3'b000, 32'hCAFEF00D);
    checkOutput("race_rsp", {rsp_valid, rsp_tag, rsp_status, rsp_data},
                {1'b1, 8'h00, 3'b000, 32'hCAFEF00D});
    checkOutput("race_outstanding", outstanding, 6'd0);
    repeat (3) @(negedge clk);
    checkOutput("race_no_timeout", toPulses - toBase, 0);

    $display("[TB] response backpressure");
    applyStimulus(1'b0, 32'h100, 32'h0);
    applyStimulus(1'b0, 32'h104, 32'h0);
    rsp_ready  = 1'b0;
    cpl_valid  = 1'b1;
    cpl_tag    = 8'h00;
    cpl_status = 3'b000;
    cpl_data   = 32'hAAAA0000;
    #1 checkOutput("bp_cpl_ready_idle", cpl_ready, 1'b1);
    @(negedge clk);
    cpl_tag    = 8'h01;
    cpl_status = 3'b001;
    cpl_data   = 32'hBBBB1111;
    for (int k = 0; k < 2; k++) begin
      #1 checkOutput($sformatf("bp_cpl_ready_low_%0d", k), cpl_ready, 1'b0);
      checkOutput($sformatf("bp_rsp_hold_%0d", k), {rsp_valid, rsp_tag, rsp_status, rsp_data},
                  {1'b1, 8'h00, 3'b000, 32'hAAAA0000});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_rsp_drained", rsp_valid, 1'b0);
    #1 checkOutput("bp_cpl_ready_back", cpl_ready, 1'b1);
    @(negedge clk);
    cpl_valid = 1'b0;
    checkOutput("bp_second_rsp", {rsp_valid, rsp_tag, rsp_status, rsp_data},
                {1'b1, 8'h01, 3'b001, 32'hBBBB1111});
    checkOutput("bp_outstanding", outstanding, 6'd0);
    @(negedge clk);

    $display("[TB] reset during held TLP");
    tlp_ready = 1'b0;
    applyStimulus(1'b0, 32'h200, 32'h0);
    checkOutput("mid_tlp_valid", tlp_valid, 1'b1);
    checkOutput("mid_outstanding", outstanding, 6'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_state", {tlp_valid, rsp_valid, outstanding}, '0);
    rst_n = 1'b1;
    tlp_ready = 1'b1;
    @(negedge clk);

    $display("[TB] link_up gating");
    link_up = 1'b0;
    req_write = 1'b1;
    #1 checkOutput("link_down_ready", req_ready, 1'b0);
    link_up = 1'b1;
    #1 checkOutput("link_up_ready", req_ready, 1'b1);
    tlp_ready = 1'b0;
    applyStimulus(1'b1, 32'h300, 32'hA5A5A5A5);
    link_up = 1'b0;
    @(negedge clk);
    checkOutput("link_drop_tlp_held", {tlp_valid, tlp_address}, {1'b1, 32'h300});
    tlp_ready = 1'b1;
    @(negedge clk);
    checkOutput("link_drop_tlp_sent", tlp_valid, 1'b0);
    link_up = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
